// File: rtl/sr_write_queue_pkg.sv
// Shared widths, defaults and entry payload for the SR write queue.
//   HBIT_TGT_GP / HBIT_DATA : high bit of the SR index / SR data word
//   SIZE_DATA               : SR data word size in bits
//   SR_WQ_DEPTH             : default queue depth (power of two, >= 2)
package sr_write_queue_pkg;

    localparam int unsigned HBIT_TGT_GP = 3;
    localparam int unsigned HBIT_DATA   = 23;
    localparam int unsigned SIZE_DATA   = HBIT_DATA + 1;
    localparam int unsigned SR_WQ_DEPTH = 4;

    localparam int unsigned SR_ADDR_W   = HBIT_TGT_GP + 1;
    localparam int unsigned SR_DATA_W   = SIZE_DATA;

    // One pending SR write
    typedef struct packed {
        logic [SR_ADDR_W-1:0] addr;
        logic [SR_DATA_W-1:0] data;
    } sr_wq_entry_t;

endpackage

// File: rtl/sr_wq_fifo.sv
// Entry storage, pointers and occupancy count for the SR write queue.
//   iw_clk, iw_rst          : clock, synchronous active-high reset
//   iw_push / iw_push_entry : enqueue one entry at the tail (ignored when full)
//   iw_pop                  : retire the head entry (ignored when empty)
//   ow_mem, ow_head         : raw storage and head pointer, for forwarding
//   ow_count, ow_full       : occupancy 0..DEPTH, full flag
module sr_wq_fifo
    import sr_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = SR_WQ_DEPTH
) (
    input  logic                                iw_clk,
    input  logic                                iw_rst,
    input  logic                                iw_push,
    input  sr_wq_entry_t                        iw_push_entry,
    input  logic                                iw_pop,
    output sr_wq_entry_t [DEPTH-1:0]            ow_mem,
    output logic [$clog2(DEPTH)-1:0]            ow_head,
    output logic [$clog2(DEPTH):0]              ow_count,
    output logic                                ow_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    sr_wq_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic                     do_push;
    logic                     do_pop;

    // Pointer/count update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        do_push = iw_push && (count_q != CNT_W'(DEPTH));
        do_pop  = iw_pop && (count_q != '0);
        if (do_push) begin
            mem_d[tail_q] = iw_push_entry;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone marks entries valid
    always_ff @(posedge iw_clk) begin
        mem_q <= mem_d;
    end

    assign ow_mem   = mem_q;
    assign ow_head  = head_q;
    assign ow_count = count_q;
    assign ow_full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sr_write_queue.sv
// SR write queue: merges system/trap and execute-stage SR writes into one
// in-order queue that drains to the SR register-file write port at one
// write per cycle, and forwards pending data to readers.
//   iw_clk, iw_rst                       : clock, synchronous active-high reset
//   iw_sys_* / ow_sys_ready              : system write request (priority)
//   iw_ex_*  / ow_ex_ready               : execute-stage write request
//   ow_write_enable/_addr/_data          : register-file write port
//   iw_fwd_addr / ow_fwd_hit/_data       : pending-write probe (youngest match)
//   ow_busy                              : queue holds at least one entry
module sr_write_queue
    import sr_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = SR_WQ_DEPTH
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_sys_valid,
    input  logic [HBIT_TGT_GP:0] iw_sys_addr,
    input  logic [HBIT_DATA:0]   iw_sys_data,
    output logic                 ow_sys_ready,
    input  logic                 iw_ex_valid,
    input  logic [HBIT_TGT_GP:0] iw_ex_addr,
    input  logic [HBIT_DATA:0]   iw_ex_data,
    output logic                 ow_ex_ready,
    output logic                 ow_write_enable,
    output logic [HBIT_TGT_GP:0] ow_write_addr,
    output logic [HBIT_DATA:0]   ow_write_data,
    input  logic [HBIT_TGT_GP:0] iw_fwd_addr,
    output logic                 ow_fwd_hit,
    output logic [HBIT_DATA:0]   ow_fwd_data,
    output logic                 ow_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sr_wq_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]         head;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     live;
    logic                     sys_fire;
    logic                     ex_fire;
    logic                     push;
    sr_wq_entry_t             push_entry;
    sr_wq_entry_t             head_entry;

    // Arbitration: system always wins; execute stalls with its inputs held
    assign ow_sys_ready = !iw_rst && !full;
    assign ow_ex_ready  = !iw_rst && !full && !iw_sys_valid;
    assign sys_fire     = iw_sys_valid && ow_sys_ready;
    assign ex_fire      = iw_ex_valid && ow_ex_ready;
    assign push         = sys_fire || ex_fire;
    assign push_entry   = sys_fire ? '{addr: iw_sys_addr, data: iw_sys_data}
                                   : '{addr: iw_ex_addr,  data: iw_ex_data};

    sr_wq_fifo #(
        .DEPTH         (DEPTH)
    ) u_fifo (
        .iw_clk        (iw_clk),
        .iw_rst        (iw_rst),
        .iw_push       (push),
        .iw_push_entry (push_entry),
        .iw_pop        (live),
        .ow_mem        (mem),
        .ow_head       (head),
        .ow_count      (count),
        .ow_full       (full)
    );

    // Masked by reset so a flushed entry never reaches the register file
    assign live            = (count != '0) && !iw_rst;
    assign head_entry      = mem[head];
    assign ow_write_enable = live;
    assign ow_write_addr   = live ? head_entry.addr : '0;
    assign ow_write_data   = live ? head_entry.data : '0;
    assign ow_busy         = live;

    // Walk oldest to youngest so the last match (the youngest) wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        ow_fwd_hit  = 1'b0;
        ow_fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (live && (CNT_W'(i) < count) && (mem[idx].addr == iw_fwd_addr)) begin
                ow_fwd_hit  = 1'b1;
                ow_fwd_data = mem[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_sr_write_queue.sv
// Directed bench for sr_write_queue: a table of single-cycle vectors plus
// hand sequences for back-to-back pushes, pointer wrap and mid-run reset.
module tb_sr_write_queue;
    import sr_write_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sys_valid, ex_valid;
    logic [HBIT_TGT_GP:0] sys_addr, ex_addr, fwd_addr;
    logic [HBIT_DATA:0]   sys_data, ex_data;
    logic                 sys_ready, ex_ready, we, fwd_hit, busy;
    logic [HBIT_TGT_GP:0] waddr;
    logic [HBIT_DATA:0]   wdata, fwd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sr_write_queue #(.DEPTH(DEPTH)) dut (
        .iw_clk          (clk),
        .iw_rst          (rst),
        .iw_sys_valid    (sys_valid),
        .iw_sys_addr     (sys_addr),
        .iw_sys_data     (sys_data),
        .ow_sys_ready    (sys_ready),
        .iw_ex_valid     (ex_valid),
        .iw_ex_addr      (ex_addr),
        .iw_ex_data      (ex_data),
        .ow_ex_ready     (ex_ready),
        .ow_write_enable (we),
        .ow_write_addr   (waddr),
        .ow_write_data   (wdata),
        .iw_fwd_addr     (fwd_addr),
        .ow_fwd_hit      (fwd_hit),
        .ow_fwd_data     (fwd_data),
        .ow_busy         (busy)
    );

    typedef struct {
        logic                 sv;
        logic [HBIT_TGT_GP:0] sa;
        logic [HBIT_DATA:0]   sd;
        logic                 ev;
        logic [HBIT_TGT_GP:0] ea;
        logic [HBIT_DATA:0]   ed;
        logic [HBIT_TGT_GP:0] fa;
        logic                 e_sr;
        logic                 e_er;
        logic                 e_we;
        logic [HBIT_TGT_GP:0] e_wa;
        logic [HBIT_DATA:0]   e_wd;
        logic                 e_hit;
        logic [HBIT_DATA:0]   e_fd;
        logic                 e_busy;
    } vec_t;

    vec_t vecs[12];

    // Reference model for the hand sequences: occupancy plus accepted/observed writes
    int          m_count;
    logic [31:0] expq[$];
    logic [31:0] obsq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic sv, input logic [HBIT_TGT_GP:0] sa, input logic [HBIT_DATA:0] sd,
                        input logic ev, input logic [HBIT_TGT_GP:0] ea, input logic [HBIT_DATA:0] ed);
        logic e_sr, e_er, e_push;
        @(negedge clk);
        sys_valid = sv; sys_addr = sa; sys_data = sd;
        ex_valid  = ev; ex_addr  = ea; ex_data  = ed;
        fwd_addr  = '0;
        #1;
        e_sr = (m_count < int'(DEPTH));
        e_er = e_sr && !sv;
        chk("step sys_ready", 32'(sys_ready), 32'(e_sr));
        chk("step ex_ready",  32'(ex_ready),  32'(e_er));
        chk("step write_enable", 32'(we),     32'(m_count != 0));
        chk("step busy",      32'(busy),      32'(m_count != 0));
        if (we) obsq.push_back(32'({waddr, wdata}));
        e_push = 1'b0;
        if (sv && e_sr) begin
            expq.push_back(32'({sa, sd}));
            e_push = 1'b1;
        end else if (ev && e_er) begin
            expq.push_back(32'({ea, ed}));
            e_push = 1'b1;
        end
        m_count = m_count + int'(e_push) - int'(m_count != 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic cmp_seq(input string tag);
        chk($sformatf("%s write count", tag), 32'(obsq.size()), 32'(expq.size()));
        for (int k = 0; k < obsq.size() && k < expq.size(); k++)
            chk($sformatf("%s write %0d", tag, k), obsq[k], expq[k]);
        obsq.delete();
        expq.delete();
    endtask

    initial begin
        // {sv,sa,sd, ev,ea,ed, fa, e_sr,e_er,e_we,e_wa,e_wd,e_hit,e_fd,e_busy}
        vecs[0]  = '{0, 0, 0,         0, 0, 0,         0, 1, 1, 0, 0, 0,         0, 0,         0};
        vecs[1]  = '{0, 0, 0,         1, 3, 24'hA5A5,  3, 1, 1, 0, 0, 0,         0, 0,         0};
        vecs[2]  = '{0, 0, 0,         0, 0, 0,         3, 1, 1, 1, 3, 24'hA5A5,  1, 24'hA5A5,  1};
        vecs[3]  = '{0, 0, 0,         0, 0, 0,         3, 1, 1, 0, 0, 0,         0, 0,         0};
        vecs[4]  = '{1, 1, 24'h11,    1, 2, 24'h22,    1, 1, 0, 0, 0, 0,         0, 0,         0};
        vecs[5]  = '{0, 0, 0,         1, 2, 24'h22,    1, 1, 1, 1, 1, 24'h11,    1, 24'h11,    1};
        vecs[6]  = '{0, 0, 0,         0, 0, 0,         2, 1, 1, 1, 2, 24'h22,    1, 24'h22,    1};
        vecs[7]  = '{0, 0, 0,         0, 0, 0,         2, 1, 1, 0, 0, 0,         0, 0,         0};
        vecs[8]  = '{0, 0, 0,         1, 5, 24'h1,     5, 1, 1, 0, 0, 0,         0, 0,         0};
        vecs[9]  = '{0, 0, 0,         1, 5, 24'h2,     5, 1, 1, 1, 5, 24'h1,     1, 24'h1,     1};
        vecs[10] = '{0, 0, 0,         0, 0, 0,         5, 1, 1, 1, 5, 24'h2,     1, 24'h2,     1};
        vecs[11] = '{0, 0, 0,         0, 0, 0,         6, 1, 1, 0, 0, 0,         0, 0,         0};

        rst = 1'b1;
        sys_valid = 1'b0; sys_addr = '0; sys_data = '0;
        ex_valid  = 1'b0; ex_addr  = '0; ex_data  = '0;
        fwd_addr  = '0;

        // Outputs held quiet while reset is asserted
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst sys_ready", 32'(sys_ready), 32'd0);
        chk("rst ex_ready",  32'(ex_ready),  32'd0);
        chk("rst write_enable", 32'(we),     32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst fwd_hit",   32'(fwd_hit),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sys_valid = vecs[i].sv; sys_addr = vecs[i].sa; sys_data = vecs[i].sd;
            ex_valid  = vecs[i].ev; ex_addr  = vecs[i].ea; ex_data  = vecs[i].ed;
            fwd_addr  = vecs[i].fa;
            #1;
            chk($sformatf("v%0d sys_ready", i),  32'(sys_ready), 32'(vecs[i].e_sr));
            chk($sformatf("v%0d ex_ready", i),   32'(ex_ready),  32'(vecs[i].e_er));
            chk($sformatf("v%0d write_enable", i), 32'(we),      32'(vecs[i].e_we));
            chk($sformatf("v%0d write_addr", i), 32'(waddr),     32'(vecs[i].e_wa));
            chk($sformatf("v%0d write_data", i), 32'(wdata),     32'(vecs[i].e_wd));
            chk($sformatf("v%0d fwd_hit", i),    32'(fwd_hit),   32'(vecs[i].e_hit));
            chk($sformatf("v%0d fwd_data", i),   32'(fwd_data),  32'(vecs[i].e_fd));
            chk($sformatf("v%0d busy", i),       32'(busy),      32'(vecs[i].e_busy));
        end

        // Five back-to-back system pushes, execute contending on the first
        m_count = 0;
        step(1'b1, 4'd8, 24'h000100, 1'b1, 4'd15, 24'h00FFFF);
        for (int i = 1; i < 5; i++)
            step(1'b1, 4'(8 + i), 24'(24'h000100 + i), 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 4'd15, 24'h00FFFF);
        idle(3);
        cmp_seq("b2b");

        // Twelve writes to distinct indices, three trips round the pointers
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0)
                step(1'b1, 4'(i), 24'($urandom), 1'b0, '0, '0);
            else
                step(1'b0, '0, '0, 1'b1, 4'(i), 24'($urandom));
            if (i % 5 == 4) idle(1);
        end
        idle(3);
        cmp_seq("wrap");

        // Reset with an entry pending: the entry must never be written
        step(1'b0, '0, '0, 1'b1, 4'd7, 24'h000777);
        @(negedge clk);
        rst = 1'b1;
        sys_valid = 1'b1; sys_addr = 4'd4; sys_data = 24'h000444;
        ex_valid  = 1'b0;
        fwd_addr  = 4'd7;
        #1;
        chk("midrst sys_ready",    32'(sys_ready), 32'd0);
        chk("midrst ex_ready",     32'(ex_ready),  32'd0);
        chk("midrst write_enable", 32'(we),        32'd0);
        chk("midrst busy",         32'(busy),      32'd0);
        chk("midrst fwd_hit",      32'(fwd_hit),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        sys_valid = 1'b0;
        m_count = 0;
        obsq.delete();
        expq.delete();
        idle(1);
        step(1'b0, '0, '0, 1'b1, 4'd9, 24'h000999);
        idle(2);
        cmp_seq("post-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
